// File: rtl/blit_sram.sv
// Single-port async SRAM responder for the arbiter's req/ack bus; read ack after RD_WAIT+1 cycles, write ack after WR_WAIT+2.
// No backpressure: a request is taken only in IDLE or the ack cycle, otherwise it is dropped and ram_err latches.
module blit_sram #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_req,
    input  logic [17:0] ram_addr,
    input  logic [15:0] ram_wdata,
    input  logic [1:0]  ram_wstrb,
    input  logic        ram_we,
    output logic        ram_ack,
    output logic [15:0] ram_rdata,
    output logic        ram_err,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);

    typedef enum logic [2:0] {IDLE, TURNWAIT, READ, WSETUP, WPULSE, WHOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  turn_q, turn_d, turn_dec, need_turn;
    logic [1:0]  wstrb_q, wstrb_d;
    logic        ack_q, ack_d, err_q, err_d;
    logic [15:0] rdata_q, rdata_d, dq_o_q, dq_o_d;
    logic [17:0] addr_q, addr_d;
    logic        dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d, lb_n_q, lb_n_d, ub_n_q, ub_n_d;

    // turn_q counts dead cycles still owed before oe_n may drop, including the current one
    assign turn_dec = (turn_q == 2'd0) ? 2'd0 : turn_q - 2'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        turn_d    = turn_q;
        wstrb_d   = wstrb_q;
        ack_d     = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        dq_o_d    = dq_o_q;
        dq_oe_d   = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        ub_n_d    = 1'b1;
        need_turn = 2'd0;

        case (state_q)
            IDLE: turn_d = turn_dec;
            TURNWAIT: begin
                if (turn_q <= 2'd1) begin
                    state_d = READ;
                    turn_d  = 2'd0;
                    cnt_d   = 4'd0;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                    lb_n_d  = 1'b0;
                    ub_n_d  = 1'b0;
                end else begin
                    turn_d = turn_q - 2'd1;
                end
            end
            READ: begin
                if (cnt_q == 4'(RD_WAIT - 1)) begin
                    rdata_d = sram_dq_i;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    ce_n_d = 1'b0;
                    oe_n_d = 1'b0;
                    lb_n_d = 1'b0;
                    ub_n_d = 1'b0;
                end
            end
            WSETUP: begin
                state_d = WPULSE;
                cnt_d   = 4'd0;
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                we_n_d  = 1'b0;
                lb_n_d  = ~wstrb_q[0];
                ub_n_d  = ~wstrb_q[1];
            end
            WPULSE: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                if (cnt_q == 4'(WR_WAIT - 1)) begin
                    state_d = WHOLD;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    we_n_d = 1'b0;
                    lb_n_d = ~wstrb_q[0];
                    ub_n_d = ~wstrb_q[1];
                end
            end
            WHOLD: begin
                state_d = IDLE;
                turn_d  = 2'(TURN);
            end
            default: state_d = IDLE;
        endcase

        if (ram_req) begin
            if (state_q == IDLE || state_q == WHOLD) begin
                addr_d  = ram_addr;
                wstrb_d = ram_wstrb;
                cnt_d   = 4'd0;
                if (ram_we) begin
                    state_d = WSETUP;
                    dq_o_d  = ram_wdata;
                    ce_n_d  = 1'b0;
                    dq_oe_d = 1'b1;
                end else begin
                    need_turn = (state_q == WHOLD) ? 2'(TURN) : turn_dec;
                    if (need_turn != 2'd0) begin
                        state_d = TURNWAIT;
                        turn_d  = need_turn;
                    end else begin
                        state_d = READ;
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        lb_n_d  = 1'b0;
                        ub_n_d  = 1'b0;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            turn_q  <= 2'd0;
            wstrb_q <= 2'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'd0;
            addr_q  <= 18'd0;
            dq_o_q  <= 16'd0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            turn_q  <= turn_d;
            wstrb_q <= wstrb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
        end
    end

    assign ram_ack    = ack_q;
    assign ram_rdata  = rdata_q;
    assign ram_err    = err_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_blit_sram.sv
// Bench for blit_sram: directed requests against an SRAM pin model, with a cycle-timeline model of expected outputs.
module tb_blit_sram;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
    localparam int TURN    = 1;
    localparam int N       = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_req, ram_we, ram_ack, ram_err;
    logic [17:0] ram_addr, sram_addr;
    logic [15:0] ram_wdata, ram_rdata, sram_dq_o, sram_dq_i;
    logic [1:0]  ram_wstrb;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    blit_sram #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN)) dut (
        .clk(clk), .rst(rst),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_we(ram_we),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata), .ram_err(ram_err),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM pin model; 16'hA5A5 on the bus when not output-enabled exposes mistimed sampling
    logic [15:0] sram_mem [0:262143];
    logic        load_mem;
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hA5A5;

    always @(posedge clk) begin
        if (load_mem) begin
            sram_mem[18'h00123] <= 16'hBEEF;
            sram_mem[18'h3FFFF] <= 16'hABCD;
            sram_mem[18'h00050] <= 16'h1111;
            sram_mem[18'h00051] <= 16'h3300;
            sram_mem[18'h00200] <= 16'h0F0F;
            sram_mem[18'h00300] <= 16'h0000;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_dq_o[7:0];
            if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_dq_o[15:8];
        end
    end

    // Expected output timeline, one entry per cycle
    logic        e_ack [0:N-1];
    logic        e_err [0:N-1];
    logic [15:0] e_rdata [0:N-1];
    logic [17:0] e_addr [0:N-1];
    logic [15:0] e_dqo [0:N-1];
    logic        e_dqoe [0:N-1];
    logic        e_ce [0:N-1];
    logic        e_oe [0:N-1];
    logic        e_we [0:N-1];
    logic        e_lb [0:N-1];
    logic        e_ub [0:N-1];

    logic [15:0] mm [logic [17:0]];
    int busy_to;
    int last_whold;
    int checks = 0;
    int errors = 0;
    logic done = 1'b0;

    function automatic logic [15:0] mm_rd(input logic [17:0] a);
        return mm.exists(a) ? mm[a] : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int c);
        for (int k = c + 1; k < N; k++) begin
            e_ack[k] = 1'b0; e_err[k] = 1'b0; e_rdata[k] = 16'd0; e_addr[k] = 18'd0;
            e_dqo[k] = 16'd0; e_dqoe[k] = 1'b0; e_ce[k] = 1'b1; e_oe[k] = 1'b1;
            e_we[k] = 1'b1; e_lb[k] = 1'b1; e_ub[k] = 1'b1;
        end
        busy_to    = c;
        last_whold = -1000;
    endtask

    task automatic model_issue(input int c, input logic we, input logic [17:0] a,
                               input logic [15:0] d, input logic [1:0] s);
        int t;
        int ack;
        logic [15:0] old;
        if (c < busy_to) begin
            for (int k = c + 1; k < N; k++) e_err[k] = 1'b1;
        end else begin
            for (int k = c + 1; k < N; k++) e_addr[k] = a;
            if (we) begin
                for (int k = c + 1; k < N; k++) e_dqo[k] = d;
                for (int k = c + 1; k <= c + WR_WAIT + 2; k++) begin
                    e_ce[k] = 1'b0; e_dqoe[k] = 1'b1;
                end
                for (int k = c + 2; k <= c + WR_WAIT + 1; k++) begin
                    e_we[k] = 1'b0; e_lb[k] = ~s[0]; e_ub[k] = ~s[1];
                end
                e_ack[c + WR_WAIT + 2] = 1'b1;
                busy_to    = c + WR_WAIT + 2;
                last_whold = c + WR_WAIT + 2;
                old = mm_rd(a);
                if (s[0]) old[7:0]  = d[7:0];
                if (s[1]) old[15:8] = d[15:8];
                mm[a] = old;
            end else begin
                t = TURN - (c - last_whold);
                if (t < 0) t = 0;
                for (int k = c + t + 1; k <= c + t + RD_WAIT; k++) begin
                    e_ce[k] = 1'b0; e_oe[k] = 1'b0; e_lb[k] = 1'b0; e_ub[k] = 1'b0;
                end
                ack = c + t + RD_WAIT + 1;
                e_ack[ack] = 1'b1;
                for (int k = ack; k < N; k++) e_rdata[k] = mm_rd(a);
                busy_to = ack;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic we, input logic [17:0] a, input logic [15:0] d, input logic [1:0] s);
        ram_req = 1'b1; ram_we = we; ram_addr = a; ram_wdata = d; ram_wstrb = s;
        model_issue(cyc, we, a, d, s);
        tick();
        ram_req = 1'b0; ram_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_mem = 1'b1;
        ram_req = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0; ram_wstrb = '0;
        mm[18'h00123] = 16'hBEEF; mm[18'h3FFFF] = 16'hABCD; mm[18'h00050] = 16'h1111;
        mm[18'h00051] = 16'h3300; mm[18'h00200] = 16'h0F0F; mm[18'h00300] = 16'h0000;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    model_reset(cyc);
                    tick();
                end
                rst = 1'b0; load_mem = 1'b0;
                check("reset_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 64'h1F);
                check("reset_ack_err_oe", 64'({ram_ack, ram_err, sram_dq_oe}), 64'h0);
                idle(2);

                // plain read of BEEF
                send(1'b0, 18'h00123, 16'h0, 2'b00);
                check("rd_strobes_c1", 64'({sram_ce_n, sram_oe_n}), 64'h0);
                idle(2);
                check("rd_ack_c3", 64'(ram_ack), 64'h1);
                check("rd_data_c3", 64'(ram_rdata), 64'hBEEF);
                check("rd_release_c3", 64'({sram_ce_n, sram_oe_n}), 64'h3);
                idle(2);

                // upper-byte write, then read one cycle after the hold cycle (no turnaround owed)
                send(1'b1, 18'h3FFFF, 16'h1234, 2'b10);
                idle(3);
                check("wr_ack_c4", 64'(ram_ack), 64'h1);
                idle(1);
                check("wr_mem_ub", 64'(sram_mem[18'h3FFFF]), 64'h12CD);
                send(1'b0, 18'h3FFFF, 16'h0, 2'b00);
                idle(2);
                check("rd_after_gap_ack", 64'({ram_ack, ram_rdata}), 64'h112CD);
                idle(2);

                // write then read issued in the write's ack cycle: one turnaround cycle
                send(1'b1, 18'h00050, 16'h7777, 2'b11);
                idle(3);
                send(1'b0, 18'h00050, 16'h0, 2'b00);
                check("turn_dead_cycle", 64'({sram_ce_n, sram_dq_oe}), 64'h2);
                idle(3);
                check("turn_rd_ack", 64'({ram_ack, ram_rdata}), 64'h17777);
                idle(2);

                // request while busy is dropped and flags an error
                send(1'b0, 18'h00200, 16'h0, 2'b00);
                idle(1);
                send(1'b1, 18'h00200, 16'hFFFF, 2'b11);
                check("busy_rd_ack", 64'({ram_ack, ram_rdata}), 64'h10F0F);
                idle(1);
                check("busy_err", 64'({ram_err, ram_ack}), 64'h2);
                idle(5);
                check("busy_not_run", 64'(sram_mem[18'h00200]), 64'h0F0F);

                // reset during the write pulse
                send(1'b1, 18'h00300, 16'h4444, 2'b11);
                idle(1);
                check("wpulse_we_low", 64'(sram_we_n), 64'h0);
                rst = 1'b1;
                model_reset(cyc);
                tick();
                rst = 1'b0;
                check("abort_pins", 64'({sram_we_n, sram_dq_oe, sram_ce_n, ram_ack}), 64'hA);
                idle(1);
                send(1'b0, 18'h00200, 16'h0, 2'b00);
                idle(2);
                check("post_reset_rd", 64'({ram_ack, ram_rdata}), 64'h10F0F);
                idle(2);

                // write with no byte enables, then read back in its ack cycle
                send(1'b1, 18'h00123, 16'hFFFF, 2'b00);
                idle(3);
                check("wstrb0_ack", 64'(ram_ack), 64'h1);
                send(1'b0, 18'h00123, 16'h0, 2'b00);
                idle(3);
                check("wstrb0_rd", 64'({ram_ack, ram_rdata}), 64'h1BEEF);
                check("wstrb0_mem", 64'(sram_mem[18'h00123]), 64'hBEEF);
                idle(3);

                // back-to-back read, read, write
                send(1'b0, 18'h00050, 16'h0, 2'b00);
                idle(2);
                send(1'b0, 18'h3FFFF, 16'h0, 2'b00);
                idle(2);
                check("b2b_rd2", 64'({ram_ack, ram_rdata}), 64'h112CD);
                send(1'b1, 18'h00051, 16'h00AA, 2'b01);
                idle(5);
                check("b2b_wr_lb", 64'(sram_mem[18'h00051]), 64'h33AA);
                idle(4);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (cyc >= 1 && cyc < N) begin
                        check("outputs",
                            {6'd0, ram_ack, ram_err, ram_rdata, sram_addr, sram_dq_o,
                             sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n},
                            {6'd0, e_ack[cyc], e_err[cyc], e_rdata[cyc], e_addr[cyc], e_dqo[cyc],
                             e_dqoe[cyc], e_ce[cyc], e_oe[cyc], e_we[cyc], e_lb[cyc], e_ub[cyc]});
                        check("bus_conflict", 64'(sram_dq_oe & ~sram_oe_n), 64'h0);
                    end
                end
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blit_sram.md
Name: blit_sram

Overview:
- Responder end of the 18-bit-address / 16-bit-data RAM request/ack interface driven by the system RAM arbiter.
- Accepts single-cycle ram_req pulses and executes one read or byte-strobed write on an external asynchronous SRAM.
- Returns a single-cycle ram_ack with read data.
- Sits between the arbiter and the board SRAM pins; tristate is split into o/i/oe for the top level.

Parameters:
RD_WAIT, 2, cycles ce_n/oe_n held low before read data is sampled (legal range 1..15)
WR_WAIT, 2, cycles we_n held low per write (legal range 1..15)
TURN, 1, dead cycles with bus undriven between a write's hold cycle and a following read's oe_n assertion (legal range 0..3)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ram_req  in  1  single-cycle request strobe
ram_addr  in  18  word address, sampled with ram_req
ram_wdata  in  16  write data, sampled with ram_req
ram_wstrb  in  2  byte enables; [1]=upper byte, [0]=lower byte
ram_we  in  1  1=write, 0=read, sampled with ram_req
ram_ack  out  1  single-cycle completion pulse
ram_rdata  out  16  read data; valid in the ack cycle, held until the next read completes
ram_err  out  1  sticky; set when ram_req arrives while busy
sram_addr  out  18  SRAM address
sram_dq_o  out  16  SRAM write data
sram_dq_i  in  16  SRAM read data
sram_dq_oe  out  1  1=drive sram_dq_o onto the pins
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_lb_n  out  1  lower byte enable, active low
sram_ub_n  out  1  upper byte enable, active low

Behaviour:
- Reset values:
  - All _n strobes = 1.
  - sram_dq_oe, ram_ack, ram_err = 0.
  - ram_rdata, sram_addr, sram_dq_o = 0.
  - State = IDLE; TURN counter cleared.
- All outputs are registered.
- States: IDLE, TURNWAIT, READ, WSETUP, WPULSE, WHOLD.
- Request acceptance:
  - ram_req is accepted in IDLE or in the ack cycle. Cycle 0 = the cycle ram_req is high.
  - addr, wdata, wstrb and we are latched at the end of cycle 0.
- Read, no pending turnaround:
  - Cycles 1..RD_WAIT: ce_n=0, oe_n=0, lb_n=ub_n=0, dq_oe=0.
  - sram_dq_i is captured into ram_rdata at the end of cycle RD_WAIT.
  - Cycle RD_WAIT+1: ram_ack=1, all strobes back to 1.
  - Latency is RD_WAIT+1 cycles.
- Read following a write:
  - If fewer than TURN cycles have elapsed since WHOLD ended, enter TURNWAIT first.
  - In TURNWAIT, ce_n=1 and dq_oe=0 until TURN dead cycles have elapsed, then proceed to READ.
  - Ack is delayed by the same count.
- Write:
  - Cycle 1 (WSETUP): ce_n=0, dq_oe=1, we_n=1, sram_dq_o=wdata.
  - Cycles 2..WR_WAIT+1 (WPULSE): we_n=0, lb_n=~wstrb[0], ub_n=~wstrb[1].
  - Cycle WR_WAIT+2 (WHOLD): we_n=1, lb_n=ub_n=1, dq_oe=1, ce_n=0, ram_ack=1.
  - sram_addr and sram_dq_o are stable across WSETUP..WHOLD.
- Write with wstrb=00: full sequence still runs with lb_n=ub_n=1 throughout; ack is still given; no SRAM byte is modified.
- ram_rdata is unchanged by writes.
- Busy conflict: ram_req while not IDLE and not in the ack cycle is ignored and sets ram_err; the current operation completes normally. ram_err clears only on rst.
- Back-to-back: a req in the ack cycle starts its cycle 1 on the next cycle; there is no idle bubble except TURNWAIT.
- Reset mid-operation: next cycle all strobes=1, dq_oe=0, state IDLE; no ack is issued for the aborted operation.
- ram_ack is never high for two consecutive cycles.

Test Plan:
- Read, RD_WAIT=2, sram_dq_i model returns 16'hBEEF at addr 18'h00123 -> ce_n/oe_n low in cycles 1-2, ram_ack in cycle 3 with ram_rdata=16'hBEEF, strobes high in cycle 3.
- Write addr 18'h3FFFF, wdata 16'h1234, wstrb=10, WR_WAIT=2 -> we_n low cycles 2-3, ub_n=0, lb_n=1, dq_oe 1-4, ack cycle 4; model memory upper byte=8'h12, lower byte unchanged.
- Write then read in the ack cycle, TURN=1 -> one cycle with ce_n=1, dq_oe=0 before oe_n=0; dq_oe and oe_n never both active; read ack at cycle RD_WAIT+2 after req.
- ram_req pulsed in cycle 2 of a read -> ram_err=1 thereafter, exactly one ack, the second request is not executed.
- rst asserted in WPULSE -> next cycle we_n=1, dq_oe=0, ce_n=1, no ack; a subsequent read of 16'h0F0F completes normally.
- Write with wstrb=00 -> lb_n=ub_n=1 throughout, ack in cycle WR_WAIT+2, memory contents unchanged.
